// File: rtl/game_status_tracker_if.sv
// Signal bundle between the board/move logic (master) and game_status_tracker (slave).
// Strobes are single-cycle pulses sampled on every rising clk edge while enable is high;
// nothing is acknowledged back, and a strobe held high for k cycles counts as k events.
interface game_status_tracker_if;
  logic       enable;
  logic       startGame;
  logic [6:0] givenCount;
  logic       moveStrobe;
  logic       moveCorrect;
  logic       cellFilled;
  logic       secTick;
  logic [1:0] registradores;
  logic [6:0] filledCount;
  logic [1:0] errorsLeft;
  logic [9:0] timeLeft;

  modport master (
    output enable, startGame, givenCount, moveStrobe, moveCorrect, cellFilled, secTick,
    input  registradores, filledCount, errorsLeft, timeLeft
  );

  modport slave (
    input  enable, startGame, givenCount, moveStrobe, moveCorrect, cellFilled, secTick,
    output registradores, filledCount, errorsLeft, timeLeft
  );
endinterface

// File: rtl/game_status_tracker.sv
// Sudoku round tracker: counts placed digits and lives, reports won (01) / lost (10).
// Define GAME_STATUS_TIMEOUT_EN to build the secTick-driven round timer.
module game_status_tracker #(
  parameter int TOTAL_CELLS = 81,
  parameter int MAX_ERRORS  = 3,
  parameter int TIME_LIMIT  = 600
) (
  input  logic                 clk,
  input  logic                 rstn,
  game_status_tracker_if.slave bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_WON     = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  localparam logic [6:0] TOTAL_W  = 7'(TOTAL_CELLS);
  localparam logic [1:0] ERRORS_W = 2'(MAX_ERRORS);

  state_t     state_q, state_d;
  logic [6:0] filled_q, filled_d;
  logic [1:0] errors_q, errors_d;
  logic [1:0] regs_q;

`ifdef GAME_STATUS_TIMEOUT_EN
  localparam logic [9:0] TIME_W = 10'(TIME_LIMIT);
  logic [9:0] time_q, time_d;
`endif

  function automatic logic [1:0] result_code(input state_t s);
    case (s)
      S_WON:   result_code = 2'b01;
      S_LOST:  result_code = 2'b10;
      default: result_code = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      filled_q <= 7'd0;
      errors_q <= ERRORS_W;
      regs_q   <= 2'b00;
`ifdef GAME_STATUS_TIMEOUT_EN
      time_q   <= TIME_W;
`endif
    end else begin
      state_q  <= state_d;
      filled_q <= filled_d;
      errors_q <= errors_d;
      regs_q   <= result_code(state_d);
`ifdef GAME_STATUS_TIMEOUT_EN
      time_q   <= time_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    filled_d = filled_q;
    errors_d = errors_q;
`ifdef GAME_STATUS_TIMEOUT_EN
    time_d   = time_q;
`endif
    if (bus.enable) begin
      // A start (or restart) pre-empts any move or tick in the same cycle.
      if ((state_q == S_IDLE || state_q == S_PLAYING) && bus.startGame) begin
        errors_d = ERRORS_W;
`ifdef GAME_STATUS_TIMEOUT_EN
        time_d   = TIME_W;
`endif
        if (int'(bus.givenCount) >= TOTAL_CELLS) begin
          filled_d = TOTAL_W;
          state_d  = S_WON;
        end else begin
          filled_d = bus.givenCount;
          state_d  = S_PLAYING;
        end
      end else if (state_q == S_PLAYING) begin
        if (bus.moveStrobe) begin
          if (!bus.moveCorrect) begin
            if (errors_q <= 2'd1) begin
              errors_d = 2'd0;
              state_d  = S_LOST;
            end else begin
              errors_d = errors_q - 2'd1;
            end
          end else if (!bus.cellFilled && filled_q < TOTAL_W) begin
            filled_d = filled_q + 7'd1;
            if (filled_q + 7'd1 == TOTAL_W) state_d = S_WON;
          end
        end
`ifdef GAME_STATUS_TIMEOUT_EN
        // Evaluated after the move so an expiring clock outranks a same-cycle win.
        if (bus.secTick) begin
          if (time_q <= 10'd1) begin
            time_d  = 10'd0;
            state_d = S_LOST;
          end else begin
            time_d = time_q - 10'd1;
          end
        end
`endif
      end
    end
  end

  assign bus.registradores = regs_q;
  assign bus.filledCount   = filled_q;
  assign bus.errorsLeft    = errors_q;
  assign state_dbg         = state_q;

`ifdef GAME_STATUS_TIMEOUT_EN
  assign bus.timeLeft = time_q;
`else
  logic unused_timer;
  assign unused_timer = ^{bus.secTick, 10'(TIME_LIMIT)};
  assign bus.timeLeft = 10'd0;
`endif

endmodule

// File: tb/tb_game_status_tracker.sv
// Self-checking bench for game_status_tracker: directed scenarios plus randomized rounds
// compared each cycle against an integer-level model of the game rules.
module tb_game_status_tracker;

  localparam int TOTAL = 81;
  localparam int MAXE  = 3;
  localparam int TL    = 5;
`ifdef GAME_STATUS_TIMEOUT_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;

  game_status_tracker_if bus();

  game_status_tracker #(
    .TOTAL_CELLS(TOTAL),
    .MAX_ERRORS (MAXE),
    .TIME_LIMIT (TL)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus.slave),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // result: 0 none, 1 won, 2 lost. active: a round has been started.
  int m_result, m_filled, m_lives, m_time;
  bit m_active;
  logic [20:0] exp_q[$];

  function automatic void model_reset();
    m_active = 1'b0;
    m_result = 0;
    m_filled = 0;
    m_lives  = MAXE;
    m_time   = TMR ? TL : 0;
  endfunction

  function automatic void model_apply(input bit en, input bit st, input int gc,
                                      input bit ms, input bit mc, input bit cf, input bit tk);
    if (!en || m_result != 0) return;
    if (st) begin
      m_active = 1'b1;
      m_filled = (gc > TOTAL) ? TOTAL : gc;
      m_lives  = MAXE;
      m_time   = TMR ? TL : 0;
      if (gc >= TOTAL) m_result = 1;
      return;
    end
    if (!m_active) return;
    if (ms && mc && !cf) begin
      m_filled = m_filled + 1;
      if (m_filled == TOTAL) m_result = 1;
    end else if (ms && !mc) begin
      m_lives = m_lives - 1;
      if (m_lives == 0) m_result = 2;
    end
    if (TMR && tk) begin
      m_time = m_time - 1;
      if (m_time == 0) m_result = 2;
    end
  endfunction

  function automatic logic [20:0] model_snap();
    return {2'(m_result), 7'(m_filled), 2'(m_lives), 10'(m_time)};
  endfunction

  function automatic logic [20:0] dut_snap();
    return {bus.registradores, bus.filledCount, bus.errorsLeft, bus.timeLeft};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit st, input int gc,
                       input bit ms, input bit mc, input bit cf, input bit tk);
    bus.enable      = en;
    bus.startGame   = st;
    bus.givenCount  = 7'(gc);
    bus.moveStrobe  = ms;
    bus.moveCorrect = mc;
    bus.cellFilled  = cf;
    bus.secTick     = tk;
    @(posedge clk);
    model_apply(en, st, gc, ms, mc, cf, tk);
    exp_q.push_back(model_snap());
    #1;
    bus.startGame  = 1'b0;
    bus.moveStrobe = 1'b0;
    bus.secTick    = 1'b0;
  endtask

  task automatic do_reset();
    bus.enable = 1'b1; bus.startGame = 1'b0; bus.givenCount = '0;
    bus.moveStrobe = 1'b0; bus.moveCorrect = 1'b0; bus.cellFilled = 1'b0; bus.secTick = 1'b0;
    rstn = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [22:0] exp;
    do_reset();
    exp = {2'd0, model_snap()};
    if ({state_dbg, dut_snap()} !== exp) begin
      $display("FAIL reset: got %h want %h", {state_dbg, dut_snap()}, exp);
      errors++;
    end
    checks++;
  endtask

  task automatic test_win_from_80();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 1, 80, 0, 0, 0, 0);
      else        drive(1, 0, 0, 1, 1, 0, 0);
      exp = exp_q.pop_front();
      if (dut_snap() !== exp) begin
        $display("FAIL win_from_80 step %0d: got %h want %h", i, dut_snap(), exp);
        errors++;
      end
      checks++;
    end
    if (bus.registradores !== 2'b01 || bus.filledCount !== 7'd81) begin
      $display("FAIL win_from_80 final: got reg=%b filled=%0d want reg=01 filled=81",
               bus.registradores, bus.filledCount);
      errors++;
    end
    checks++;
  endtask

  task automatic test_lose_errors();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 1, 30, 0, 0, 0, 0);
      else        drive(1, 0, 0, 1, 0, i[0], 0);
      exp = exp_q.pop_front();
      if (dut_snap() !== exp) begin
        $display("FAIL lose_errors step %0d: got %h want %h", i, dut_snap(), exp);
        errors++;
      end
      checks++;
    end
    if (bus.registradores !== 2'b10 || bus.errorsLeft !== 2'd0) begin
      $display("FAIL lose_errors final: got reg=%b lives=%0d want reg=10 lives=0",
               bus.registradores, bus.errorsLeft);
      errors++;
    end
    checks++;
  endtask

  task automatic test_filled_and_enable();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1, 1, 40, 0, 0, 0, 0);
        1:       drive(1, 0, 0, 1, 1, 1, 0);
        default: drive(0, 0, 0, 1, 1, 0, 1);
      endcase
      exp = exp_q.pop_front();
      if (dut_snap() !== exp || bus.filledCount !== 7'd40) begin
        $display("FAIL filled_and_enable step %0d: got %h want %h (filled 40)", i, dut_snap(), exp);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_restart_priority();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drive(1, 1, 30, 0, 0, 0, 0);
      else if (i < 3)  drive(1, 0, 0, 1, 0, 0, 0);
      else             drive(1, 1, 30, 1, 0, 0, 0);
      exp = exp_q.pop_front();
      if (dut_snap() !== exp) begin
        $display("FAIL restart_priority step %0d: got %h want %h", i, dut_snap(), exp);
        errors++;
      end
      checks++;
    end
    if (bus.errorsLeft !== 2'd3 || bus.registradores !== 2'b00) begin
      $display("FAIL restart_priority final: got lives=%0d reg=%b want lives=3 reg=00",
               bus.errorsLeft, bus.registradores);
      errors++;
    end
    checks++;
  endtask

  task automatic test_async_reset();
    logic [22:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        @(posedge clk);
        #3 rstn = 1'b0;
        model_reset();
        #1;
      end else begin
        drive(1, 1, 81, 0, 0, 0, 0);
        void'(exp_q.pop_front());
      end
      exp = {(i == 1) ? 2'd0 : state_dbg, model_snap()};
      if ({state_dbg, dut_snap()} !== exp) begin
        $display("FAIL async_reset step %0d: got %h want %h", i, {state_dbg, dut_snap()}, exp);
        errors++;
      end
      checks++;
      if (i == 1) begin
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    if (bus.registradores !== 2'b01) begin
      $display("FAIL async_reset rewin: got reg=%b want 01", bus.registradores);
      errors++;
    end
    checks++;
  endtask

  task automatic test_timer();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1, 1, 10, 0, 0, 0, 0);
      else        drive(1, 0, 0, 0, 0, 0, 1);
      exp = exp_q.pop_front();
      if (dut_snap() !== exp) begin
        $display("FAIL timer step %0d: got %h want %h", i, dut_snap(), exp);
        errors++;
      end
      checks++;
    end
    if (bus.registradores !== (TMR ? 2'b10 : 2'b00)) begin
      $display("FAIL timer final: got reg=%b want %b", bus.registradores, TMR ? 2'b10 : 2'b00);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (m_result != 0 && $urandom_range(0, 5) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) != 0,
              $urandom_range(0, m_active ? 40 : 3) == 0,
              $urandom_range(55, 85),
              $urandom_range(0, 1),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0);
        exp = exp_q.pop_front();
        if (dut_snap() !== exp) begin
          $display("FAIL random cycle %0d: got %h want %h", i, dut_snap(), exp);
          errors++;
        end
        checks++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn = 1'b0;
    bus.enable = 1'b0; bus.startGame = 1'b0; bus.givenCount = '0;
    bus.moveStrobe = 1'b0; bus.moveCorrect = 1'b0; bus.cellFilled = 1'b0; bus.secTick = 1'b0;
    model_reset();
    test_reset();
    test_win_from_80();
    test_lose_errors();
    test_filled_and_enable();
    test_restart_priority();
    test_async_reset();
    test_timer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
